// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for the 5-stage RV32 pipeline: operand forwarding, load-use stalls,
// redirect flushes and a freeze while the data memory is busy, with event counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      if_id_instr,
  input  logic [4:0]       id_ex_rs1,
  input  logic [4:0]       id_ex_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             ex_taken,
  input  logic [4:0]       ex_mem_rd,
  input  logic             ex_mem_regwr,
  input  logic             ex_mem_memacc,
  input  logic [4:0]       mem_wb_rd,
  input  logic             mem_wb_regwr,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int unsigned TimerW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(MEM_TIMEOUT - 1);

  typedef enum logic {StRun, StMemWait} state_e;

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q, wait_cnt_q;

  logic [4:0] if_rs1, if_rs2;
  logic       in_wait, mem_entry, freeze, load_use, redirect, stall, timeout;
  logic       unused_instr;

  assign if_rs1       = if_id_instr[19:15];
  assign if_rs2       = if_id_instr[24:20];
  assign unused_instr = ^{if_id_instr[31:25], if_id_instr[14:0]};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // EX/MEM result is younger than MEM/WB, so it takes precedence.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (ex_mem_regwr && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs)) return 2'b10;
    if (mem_wb_regwr && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    in_wait   = (state_q == StMemWait);
    mem_entry = !in_wait && ex_mem_memacc && !dmem_ready;
    freeze    = in_wait || mem_entry;
    load_use  = id_ex_memread && (id_ex_rd != 5'd0) &&
                ((id_ex_rd == if_rs1) || (id_ex_rd == if_rs2));
    redirect  = !freeze && ex_taken;
    stall     = !freeze && !ex_taken && load_use;
    timeout   = in_wait && !dmem_ready && (timer_q == TimerLast);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    mem_err_d = mem_err_q || timeout;
    case (state_q)
      StRun: begin
        if (mem_entry) state_d = StMemWait;
      end
      StMemWait: begin
        if (dmem_ready || timeout) state_d = StRun;
        else timer_d = timer_q + TimerW'(1);
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      timer_q     <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mem_err_q <= mem_err_d;
      if (stall)    stall_cnt_q <= sat_inc(stall_cnt_q);
      if (redirect) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (in_wait)  wait_cnt_q  <= sat_inc(wait_cnt_q);
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      // Hold everything upstream of MEM; only the WB slot drains as a bubble.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign fwd_a     = reset ? 2'b00 : fwd_sel(id_ex_rs1);
  assign fwd_b     = reset ? 2'b00 : fwd_sel(id_ex_rs2);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences and a random
// run against a cycle-level reference model; a narrow-counter copy checks saturation.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_id_instr;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic        id_ex_memread, ex_taken, ex_mem_regwr, ex_mem_memacc, mem_wb_regwr, dmem_ready;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write;
  logic        mem_wb_flush, mem_err;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt, wait_cnt;

  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush;
  logic        s_ex_mem_write, s_mem_wb_flush, s_mem_err;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [2:0]  s_stall_cnt, s_flush_cnt, s_wait_cnt;

  logic [6:0]  ctrl_w, s_ctrl_w;
  assign ctrl_w   = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                     ex_mem_write, mem_wb_flush};
  assign s_ctrl_w = {s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush,
                     s_ex_mem_write, s_mem_wb_flush};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .if_id_instr(if_id_instr),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .ex_taken(ex_taken),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwr(ex_mem_regwr), .ex_mem_memacc(ex_mem_memacc),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwr(mem_wb_regwr), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
    .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .if_id_instr(if_id_instr),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_memread(id_ex_memread), .ex_taken(ex_taken),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwr(ex_mem_regwr), .ex_mem_memacc(ex_mem_memacc),
    .mem_wb_rd(mem_wb_rd), .mem_wb_regwr(mem_wb_regwr), .dmem_ready(dmem_ready),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
    .id_ex_write(s_id_ex_write), .id_ex_flush(s_id_ex_flush), .ex_mem_write(s_ex_mem_write),
    .mem_wb_flush(s_mem_wb_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .wait_cnt(s_wait_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: unbounded event counts, clipped when compared.
  bit m_wait;
  int m_timer, m_stall, m_flush, m_wcnt;
  bit m_err;

  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_STALL  = 7'b0001110;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_RESET  = 7'b1111111;

  typedef struct {
    logic [4:0] rs1_if, rs2_if, id_rs1, id_rs2, id_rd;
    logic       memread, taken;
    logic [4:0] exrd;
    logic       exwr;
    logic [4:0] wbrd;
    logic       wbwr;
    logic [6:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int clip(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit ref_lu();
    return id_ex_memread && (id_ex_rd != 0) &&
           ((id_ex_rd == if_id_instr[19:15]) || (id_ex_rd == if_id_instr[24:20]));
  endfunction

  function automatic int ref_fwd(input logic [4:0] rs);
    if (reset) return 0;
    if (ex_mem_regwr && ex_mem_rd != 0 && ex_mem_rd == rs) return 2;
    if (mem_wb_regwr && mem_wb_rd != 0 && mem_wb_rd == rs) return 1;
    return 0;
  endfunction

  task automatic check_all(input string tag);
    bit   frozen;
    logic [6:0] c;
    frozen = m_wait || (ex_mem_memacc && !dmem_ready);
    if (reset)          c = C_RESET;
    else if (frozen)    c = C_FREEZE;
    else if (ex_taken)  c = C_REDIR;
    else if (ref_lu())  c = C_STALL;
    else                c = C_RUN;
    chk({tag, " ctrl"}, int'(ctrl_w), int'(c));
    chk({tag, " fwd_a"}, int'(fwd_a), ref_fwd(id_ex_rs1));
    chk({tag, " fwd_b"}, int'(fwd_b), ref_fwd(id_ex_rs2));
    chk({tag, " mem_err"}, int'(mem_err), int'(m_err));
    chk({tag, " stall_cnt"}, int'(stall_cnt), clip(m_stall, 16));
    chk({tag, " flush_cnt"}, int'(flush_cnt), clip(m_flush, 16));
    chk({tag, " wait_cnt"}, int'(wait_cnt), clip(m_wcnt, 16));
    chk({tag, " s_ctrl"}, int'(s_ctrl_w), int'(c));
    chk({tag, " s_mem_err"}, int'(s_mem_err), int'(m_err));
    chk({tag, " s_stall_cnt"}, int'(s_stall_cnt), clip(m_stall, 3));
    chk({tag, " s_flush_cnt"}, int'(s_flush_cnt), clip(m_flush, 3));
    chk({tag, " s_wait_cnt"}, int'(s_wait_cnt), clip(m_wcnt, 3));
  endtask

  task automatic model_step();
    bit frozen;
    if (reset) begin
      m_wait = 0; m_timer = 0; m_err = 0; m_stall = 0; m_flush = 0; m_wcnt = 0;
    end else begin
      frozen = m_wait || (ex_mem_memacc && !dmem_ready);
      if (!frozen) begin
        if (ex_taken) m_flush++;
        else if (ref_lu()) m_stall++;
      end
      if (m_wait) begin
        m_wcnt++;
        if (dmem_ready) m_wait = 0;
        else if (m_timer == TIMEOUT - 1) begin m_wait = 0; m_err = 1; end
        else m_timer++;
      end else if (ex_mem_memacc && !dmem_ready) begin
        m_wait = 1;
      end
      if (!m_wait) m_timer = 0;
    end
  endtask

  task automatic settle(input string tag);
    #2;
    check_all(tag);
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    if_id_instr = '0; id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0; id_ex_memread = 0;
    ex_taken = 0; ex_mem_rd = '0; ex_mem_regwr = 0; ex_mem_memacc = 0;
    mem_wb_rd = '0; mem_wb_regwr = 0; dmem_ready = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2);
    if_id_instr = {7'h00, rs2, rs1, 15'h0013};
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    settle("reset");
    advance();
    reset = 0;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00};
    tbl[1]  = '{5, 0, 1, 2, 5, 1, 0, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00};
    tbl[2]  = '{3, 9, 1, 2, 9, 1, 0, 0, 0, 0, 0, C_STALL, 2'b00, 2'b00};
    tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, C_RUN, 2'b00, 2'b00};
    tbl[4]  = '{0, 0, 7, 3, 0, 0, 0, 7, 1, 7, 1, C_RUN, 2'b10, 2'b00};
    tbl[5]  = '{0, 0, 7, 3, 0, 0, 0, 7, 0, 7, 1, C_RUN, 2'b01, 2'b00};
    tbl[6]  = '{0, 0, 12, 12, 0, 0, 0, 12, 1, 12, 1, C_RUN, 2'b10, 2'b10};
    tbl[7]  = '{5, 0, 1, 2, 5, 1, 1, 0, 0, 0, 0, C_REDIR, 2'b00, 2'b00};
    tbl[8]  = '{6, 7, 1, 2, 5, 1, 0, 0, 0, 0, 0, C_RUN, 2'b00, 2'b00};
    tbl[9]  = '{0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, C_RUN, 2'b00, 2'b00};
    tbl[10] = '{0, 0, 3, 4, 0, 0, 0, 9, 1, 4, 1, C_RUN, 2'b00, 2'b01};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_REDIR, 2'b00, 2'b00};

    idle_inputs();
    reset = 1;
    m_wait = 0; m_timer = 0; m_err = 0; m_stall = 0; m_flush = 0; m_wcnt = 0;
    #1;
    advance();
    settle("reset hold");
    chk("reset ctrl", int'(ctrl_w), int'(C_RESET));
    chk("reset stall_cnt", int'(stall_cnt), 0);
    chk("reset mem_err", int'(mem_err), 0);
    advance();
    reset = 0;

    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      set_instr(tbl[i].rs1_if, tbl[i].rs2_if);
      id_ex_rs1 = tbl[i].id_rs1; id_ex_rs2 = tbl[i].id_rs2; id_ex_rd = tbl[i].id_rd;
      id_ex_memread = tbl[i].memread; ex_taken = tbl[i].taken;
      ex_mem_rd = tbl[i].exrd; ex_mem_regwr = tbl[i].exwr;
      mem_wb_rd = tbl[i].wbrd; mem_wb_regwr = tbl[i].wbwr;
      dmem_ready = 1;
      settle($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d ctrl", i), int'(ctrl_w), int'(tbl[i].ctrl));
      chk($sformatf("tbl%0d fwd_a", i), int'(fwd_a), int'(tbl[i].fa));
      chk($sformatf("tbl%0d fwd_b", i), int'(fwd_b), int'(tbl[i].fb));
      advance();
    end

    // Single load-use bubble
    do_reset();
    id_ex_memread = 1; id_ex_rd = 5; set_instr(5, 0);
    settle("lu1");
    chk("lu1 ctrl", int'(ctrl_w), int'(C_STALL));
    advance();
    id_ex_memread = 0; id_ex_rd = 0;
    settle("lu2");
    chk("lu2 ctrl", int'(ctrl_w), int'(C_RUN));
    chk("lu2 stall_cnt", int'(stall_cnt), 1);
    advance();

    // Redirect beats load-use
    do_reset();
    id_ex_memread = 1; id_ex_rd = 5; set_instr(5, 0); ex_taken = 1;
    settle("rd1");
    chk("rd1 ctrl", int'(ctrl_w), int'(C_REDIR));
    advance();
    idle_inputs();
    settle("rd2");
    chk("rd2 flush_cnt", int'(flush_cnt), 1);
    chk("rd2 stall_cnt", int'(stall_cnt), 0);
    advance();

    // Memory wait with a redirect pending during the freeze
    do_reset();
    ex_mem_memacc = 1; dmem_ready = 0; ex_taken = 1;
    for (int i = 0; i < 3; i++) begin
      settle("mw");
      chk($sformatf("mw%0d ctrl", i), int'(ctrl_w), int'(C_FREEZE));
      advance();
    end
    dmem_ready = 1;
    settle("mw3");
    chk("mw3 ctrl", int'(ctrl_w), int'(C_FREEZE));
    chk("mw3 wait_cnt", int'(wait_cnt), 2);
    chk("mw3 flush_cnt", int'(flush_cnt), 0);
    advance();
    ex_mem_memacc = 0; dmem_ready = 0;
    settle("mw4");
    chk("mw4 ctrl", int'(ctrl_w), int'(C_REDIR));
    advance();
    idle_inputs();
    settle("mw5");
    chk("mw5 flush_cnt", int'(flush_cnt), 1);
    chk("mw5 wait_cnt", int'(wait_cnt), 3);
    advance();

    // Timeout, then reset while waiting again
    do_reset();
    ex_mem_memacc = 1; dmem_ready = 0;
    for (int i = 0; i <= int'(TIMEOUT); i++) begin
      settle("to");
      chk($sformatf("to%0d mem_err", i), int'(mem_err), 0);
      advance();
    end
    settle("to_err");
    chk("to mem_err set", int'(mem_err), 1);
    chk("to reentry ctrl", int'(ctrl_w), int'(C_FREEZE));
    advance();
    reset = 1;
    settle("to_rst");
    chk("to_rst ctrl", int'(ctrl_w), int'(C_RESET));
    advance();
    reset = 0; ex_mem_memacc = 0;
    settle("to_after");
    chk("to_after mem_err", int'(mem_err), 0);
    chk("to_after ctrl", int'(ctrl_w), int'(C_RUN));
    advance();

    // Saturation of the narrow counters
    do_reset();
    id_ex_memread = 1; id_ex_rd = 3; set_instr(0, 3);
    for (int i = 0; i < 10; i++) begin
      settle("sat");
      advance();
    end
    idle_inputs();
    settle("sat_end");
    chk("sat s_stall_cnt", int'(s_stall_cnt), 7);
    chk("sat stall_cnt", int'(stall_cnt), 10);
    advance();

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 59) == 0);
      if_id_instr   = $urandom();
      if_id_instr[19:15] = 5'($urandom_range(0, 7));
      if_id_instr[24:20] = 5'($urandom_range(0, 7));
      id_ex_rs1     = 5'($urandom_range(0, 7));
      id_ex_rs2     = 5'($urandom_range(0, 7));
      id_ex_rd      = 5'($urandom_range(0, 7));
      id_ex_memread = 1'($urandom_range(0, 1));
      ex_taken      = ($urandom_range(0, 3) == 0);
      ex_mem_rd     = 5'($urandom_range(0, 7));
      ex_mem_regwr  = 1'($urandom_range(0, 1));
      ex_mem_memacc = ($urandom_range(0, 3) == 0);
      mem_wb_rd     = 5'($urandom_range(0, 7));
      mem_wb_regwr  = 1'($urandom_range(0, 1));
      dmem_ready    = ($urandom_range(0, 3) == 0);
      settle($sformatf("rnd%0d", i));
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
